// File: rtl/sar_search_5b_pkg.sv
// Shared definitions for the 5-bit successive-approximation search controller.
// Holds the state encoding, the operand width shared with the 5-bit magnitude
// comparator, and the limits of the per-bit settle counter.
package sar_search_5b_pkg;

    // Operand width shared with the companion magnitude comparator
    localparam int SAR_WIDTH = 5;

    // Largest supported number of extra settle cycles per bit
    localparam int SETTLE_MAX = 7;

    // Width of the settle counter, enough to hold SETTLE_MAX
    localparam int SETTLE_CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TEST = 2'd1,
        ST_DONE = 2'd2
    } sar_state_t;

endpackage

// File: rtl/sar_search_5b_settle.sv
// Per-bit settle counter for the successive-approximation controller.
// Counts the cycles spent on the current trial bit and flags the cycle on
// which the comparator decision is to be sampled (count == SETTLE).
module sar_settle_cnt
    import sar_search_5b_pkg::*;
#(
    parameter int SETTLE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic last
);

    localparam logic [SETTLE_CNT_W-1:0] SETTLE_V = SETTLE_CNT_W'(SETTLE);

    logic [SETTLE_CNT_W-1:0] count;

    assign last = run && (count == SETTLE_V);

    // Count cycles within the current bit; restart from 0 when a bit ends or outside a search
    always_ff @(posedge clk) begin
        if (!rst_n || !run || last) begin
            count <= '0;
        end else begin
            count <= count + SETTLE_CNT_W'(1);
        end
    end

endmodule

// File: rtl/sar_search_5b.sv
// Successive-approximation search controller.
// Drives a threshold (trial) into an external magnitude comparator, reads
// back its decision (cmp_in = sample >= trial) and binary-searches the
// unknown sample MSB first, one bit per SETTLE+1 cycles. The final value is
// published on result with a one-cycle done pulse; valid marks that result
// holds a completed conversion since reset.
module sar_search_5b
    import sar_search_5b_pkg::*;
#(
    parameter int WIDTH  = SAR_WIDTH,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_in,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             valid
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    sar_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] cur_mask;
    logic [WIDTH-1:0] next_acc;
    logic             in_test;
    logic             bit_last;

    assign in_test  = (state == ST_TEST);
    // Bit currently under test, and the accumulator once the decision for it is applied
    assign cur_mask = WIDTH'(1) << idx;
    assign next_acc = cmp_in ? (acc | cur_mask) : (acc & ~cur_mask);

    sar_settle_cnt #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (in_test),
        .last  (bit_last)
    );

    // Search FSM with registered outputs; trial is precomputed so it is stable for the whole bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            idx    <= '0;
            acc    <= '0;
            trial  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            valid  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_TEST;
                        idx   <= IDX_W'(WIDTH - 1);
                        acc   <= '0;
                        trial <= WIDTH'(1) << (WIDTH - 1);
                        busy  <= 1'b1;
                    end else begin
                        trial <= '0;
                        busy  <= 1'b0;
                    end
                end

                ST_TEST: begin
                    // cmp_in only matters on the last cycle of each bit
                    if (bit_last) begin
                        acc <= next_acc;
                        if (idx != '0) begin
                            idx   <= idx - IDX_W'(1);
                            trial <= next_acc | (cur_mask >> 1);
                        end else begin
                            state  <= ST_DONE;
                            result <= next_acc;
                            valid  <= 1'b1;
                            done   <= 1'b1;
                            busy   <= 1'b0;
                            trial  <= '0;
                        end
                    end
                end

                ST_DONE: begin
                    // start is ignored here; it is only sampled again from IDLE
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    trial <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sar_search_5b.md
Name: sar_search_5b

Overview:
- Successive-approximation controller that sits on the opposite end of the team's 5-bit magnitude comparator.
- It drives the comparator's threshold operand (trial). It reads back the comparator's decision bit (cmp_in = 1 when sample >= trial, 0 when sample < trial).
- Over WIDTH steps it binary-searches the unknown 5-bit sample value and reports it on result.
- Used wherever an unknown quantity is available only through a comparator, e.g. threshold/level detection feeding display logic.

Parameters:
WIDTH, 5, width of trial/result and number of search steps
SETTLE, 0, extra clock cycles per step between driving trial and sampling cmp_in (0..7)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request a conversion; sampled only in IDLE
cmp_in  input  1  comparator decision: 1 = sample >= trial, 0 = sample < trial
trial  output  WIDTH  threshold driven to comparator B operand
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when result is updated
result  output  WIDTH  last completed conversion, held until next done
valid  output  1  result holds a completed conversion since reset

Behaviour:
- Interface (decided): one clock; reset is synchronous and active-low, ports clk and rst_n.
- Reset (rst_n=0 at a clk edge): state=IDLE. trial=0, busy=0, done=0, result=0, valid=0. Step index and settle counter are cleared.
- Reset mid-conversion aborts immediately. No done is produced, and the previous result is lost (zeroed).
- States:
  - IDLE: trial=0, busy=0. start=1 -> TEST, with bit index i=WIDTH-1, acc=0, settle count=0.
  - TEST: trial = acc | (1<<i), lower bits zero. busy=1.
    - Remain SETTLE+1 cycles per bit. On the last cycle of the bit, sample cmp_in.
    - cmp_in=1: acc[i] kept 1. cmp_in=0: acc[i] cleared.
    - If i>0: i decrements and settle count resets. If i==0: register result=final acc, go to DONE.
  - DONE: done=1 for exactly one cycle, valid=1, busy=0, trial=0. Unconditionally -> IDLE.
- Latency: start seen at edge E0. TEST occupies WIDTH*(SETTLE+1) cycles. done is high in the cycle after the last TEST cycle. With defaults: done at cycle 6 after start, and result valid in that cycle.
- Back-to-back: start is accepted again from IDLE, i.e. the cycle after done. Minimum period = WIDTH*(SETTLE+1)+2 cycles.
- start while busy (TEST or DONE) is ignored, not queued.
- result/valid change only on done or reset. Starting a new conversion does not clear valid or result.
- cmp_in is used only on the sampling cycle. Its value at other times, including during settle cycles, has no effect.
- Boundaries:
  - All cmp_in=1 gives result=2^WIDTH-1 (31). All cmp_in=0 gives 0.
  - No wrap-around: trial never exceeds 2^WIDTH-1.
  - Simultaneous rst_n=0 and start=1: reset wins.

Decomposition:
- Shared package holds:
  - FSM state encoding constants (IDLE, TEST, DONE).
  - Default WIDTH=5, so this block and the comparator share one operand width.
  - SETTLE maximum (7) and settle-counter width (3).
- One natural sub-module: sar_settle_cnt. It is a small counter that loads 0 at each bit start and flags "last cycle of bit" when it equals SETTLE.
- All other logic lives in the top FSM.
- The bench instantiates the existing 5-bit comparator with A=sample and B=trial, and feeds its output to cmp_in.

Test Plan:
- Sample 19, defaults, start pulse -> trial sequence 16,24,20,18,19 on cycles 1-5. done=1 on cycle 6 with result=19, valid=1. busy high cycles 1-5 only.
- Sample 0, then sample 31 back-to-back (start the cycle after done) -> results 0 then 31. Trials 16,8,4,2,1 then 16,24,28,30,31. Each done is exactly one cycle wide.
- SETTLE=2, sample 10 -> each trial held 3 cycles (16,8,12,10,11). done on cycle 16 with result=10. Forcing cmp_in to the wrong value on non-sampling cycles leaves the result unchanged.
- start held high throughout a conversion, sample 7 -> only one conversion until IDLE. Result=7, then a new conversion begins the cycle after done.
- rst_n=0 on cycle 3 of a conversion with result=19 valid -> next cycle trial=0, busy=0, result=0, valid=0, no done. A fresh start with sample 5 gives result=5.
- Reset coincident with start in IDLE -> stays IDLE, busy=0. Start on the following cycle is accepted normally.
